terrain_dig_writer: RTL and testbench
=====================================

TERRAIN_DIG_WRITER -- requirements
Module: terrain_dig_writer

Interface
REQ-001 SHALL have parameter board_position_X, default 11'd32, board left edge in pixels.
REQ-002 SHALL have parameter board_position_Y, default 11'd160, board top edge in pixels.
REQ-003 SHALL have parameter PLAYER_SIZE, default 32, player sprite side in pixels.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 resetN  in  1  reset, synchronous, active-low.
REQ-006 startOfFrame  in  1  one-cycle pulse per video frame.
REQ-007 dig_enable  in  1  player is digging this frame.
REQ-008 player_topLeftX  in  11  player top-left X, pixels.
REQ-009 player_topLeftY  in  11  player top-left Y, pixels.
REQ-010 wr_ready  in  1  terrain bitmap accepts a write this cycle.
REQ-011 wr_valid  out  1  write request to terrain bitmap.
REQ-012 wr_col  out  6  target cell column, 0..59.
REQ-013 wr_row  out  6  target cell row, 0..39.
REQ-014 wr_data  out  1  cell value; constant 0 (dug).
REQ-015 busy  out  1  scan in progress.
REQ-016 cells_dug_count  out  12  accepted-write counter (see Configuration).

Function
REQ-017 Board SHALL be 480x320 pixels as 8x8-pixel cells: 60 columns x 40 rows.
REQ-018 FSM states SHALL be IDLE, LATCH, SCAN, DONE.
REQ-019 IDLE->LATCH SHALL occur only when startOfFrame=1 and dig_enable=1; player position is captured that cycle.
REQ-020 LATCH SHALL compute footprint cell ranges from captured position: col_lo=(X-board_position_X)>>3, col_hi=(X+PLAYER_SIZE-1-board_position_X)>>3; rows likewise with Y; arithmetic at least 12-bit signed.
REQ-021 Ranges SHALL be clipped to 0..59 columns and 0..39 rows; if the footprint lies fully outside the board, LATCH->IDLE with no write issued.
REQ-022 Otherwise LATCH->SCAN; wr_valid SHALL assert in the cycle after LATCH, i.e. two cycles after the startOfFrame pulse.
REQ-023 SCAN SHALL visit cells row-major: row outer ascending, column inner ascending.
REQ-024 wr_valid, wr_col, wr_row SHALL stay stable while wr_valid=1 and wr_ready=0; a write is accepted on a cycle with wr_valid=1 and wr_ready=1.
REQ-025 After each accepted write the next cell SHALL be presented the following cycle with no bubble.
REQ-026 Acceptance of the last cell (row_hi, col_hi) SHALL move SCAN->DONE; DONE->IDLE unconditionally next cycle.
REQ-027 busy SHALL be 1 in LATCH, SCAN, DONE and 0 in IDLE.
REQ-028 startOfFrame while busy=1 SHALL be ignored; position changes while busy=1 SHALL not affect the scan in progress.
REQ-029 wr_valid SHALL be 0 in IDLE, LATCH and DONE.

Reset
REQ-030 resetN=0 at a rising clk edge SHALL force IDLE, wr_valid=0, wr_col=0, wr_row=0, busy=0, cells_dug_count=0, even mid-scan; the scan is abandoned, not resumed.
REQ-031 wr_data SHALL be 0 at all times including reset.

Configuration
REQ-032 Macro TERRAIN_DIG_STATS_EN SHALL control cells_dug_count.
REQ-033 With TERRAIN_DIG_STATS_EN defined: cells_dug_count SHALL increment by 1 per accepted write and saturate at 4095.
REQ-034 Without it: cells_dug_count SHALL be constant 0 and no counter register exists.

Verification
REQ-035 Player (32,160), dig_enable=1, wr_ready=1, SOF pulse -> 16 writes, cols 0..3 x rows 0..3, first wr_valid 2 cycles after SOF, busy low 1 cycle after last write.
REQ-036 Player (36,160) -> 20 writes, cols 0..4 x rows 0..3, in row-major order.
REQ-037 Player (0,160) -> no writes, busy high for exactly 1 cycle; player (500,160) -> 8 writes, cols 58..59 x rows 0..3.
REQ-038 Player (32,160), wr_ready toggles 1,0,0,1 repeatedly -> wr_col/wr_row held while stalled, 16 writes total, none duplicated or skipped.
REQ-039 resetN=0 after 5th accepted write -> next cycle wr_valid=0, busy=0, count=0; SOF pulses during a scan -> no extra scan started.
REQ-040 TERRAIN_DIG_STATS_EN defined, 300 SOFs at (32,160) -> count saturates at 4095; undefined -> count stays 0.

Source files
------------

// File: rtl/terrain_dig_writer.sv
// Terrain dig writer: converts the player footprint into a row-major stream of
// "dug" cell writes to the 60x40 terrain bitmap. Optional TERRAIN_DIG_STATS_EN adds a saturating write counter.
module terrain_dig_writer #(
    parameter logic [10:0] board_position_X = 11'd32,
    parameter logic [10:0] board_position_Y = 11'd160,
    parameter int          PLAYER_SIZE      = 32
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        dig_enable,
    input  logic [10:0] player_topLeftX,
    input  logic [10:0] player_topLeftY,
    input  logic        wr_ready,
    output logic        wr_valid,
    output logic [5:0]  wr_col,
    output logic [5:0]  wr_row,
    output logic        wr_data,
    output logic        busy,
    output logic [11:0] cells_dug_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        SCAN  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic signed [12:0] COL_MAX = 13'sd59;
    localparam logic signed [12:0] ROW_MAX = 13'sd39;
    localparam logic signed [12:0] SIZE_M1 = 13'(PLAYER_SIZE - 1);
    localparam logic signed [12:0] BOARD_X = $signed({2'b00, board_position_X});
    localparam logic signed [12:0] BOARD_Y = $signed({2'b00, board_position_Y});

    // Clamp a signed cell index into 0..maxV.
    function automatic logic [5:0] clipCell(input logic signed [12:0] v,
                                            input logic signed [12:0] maxV);
        logic [5:0] res;
        if (v < 13'sd0) begin
            res = 6'd0;
        end else if (v > maxV) begin
            res = maxV[5:0];
        end else begin
            res = v[5:0];
        end
        return res;
    endfunction

    state_t      state_r;
    state_t      nextState_s;
    logic [10:0] posX_r;
    logic [10:0] posY_r;
    logic [5:0]  colLo_r;
    logic [5:0]  colHi_r;
    logic [5:0]  rowHi_r;
    logic [5:0]  col_r;
    logic [5:0]  row_r;
    logic        wrValid_r;
    logic        busy_r;

    logic signed [12:0] colLoRaw_s;
    logic signed [12:0] colHiRaw_s;
    logic signed [12:0] rowLoRaw_s;
    logic signed [12:0] rowHiRaw_s;
    logic               outside_s;
    logic [5:0]         colLoClip_s;
    logic [5:0]         colHiClip_s;
    logic [5:0]         rowLoClip_s;
    logic [5:0]         rowHiClip_s;
    logic               accept_s;
    logic               lastCell_s;
    logic               wrValidNext_s;
    logic               busyNext_s;

    // Footprint cell range of the captured position, clipped to the board.
    always_comb begin
        colLoRaw_s  = ($signed({2'b00, posX_r}) - BOARD_X) >>> 3;
        colHiRaw_s  = ($signed({2'b00, posX_r}) + SIZE_M1 - BOARD_X) >>> 3;
        rowLoRaw_s  = ($signed({2'b00, posY_r}) - BOARD_Y) >>> 3;
        rowHiRaw_s  = ($signed({2'b00, posY_r}) + SIZE_M1 - BOARD_Y) >>> 3;
        outside_s   = (colHiRaw_s < 13'sd0) || (colLoRaw_s > COL_MAX) ||
                      (rowHiRaw_s < 13'sd0) || (rowLoRaw_s > ROW_MAX);
        colLoClip_s = clipCell(colLoRaw_s, COL_MAX);
        colHiClip_s = clipCell(colHiRaw_s, COL_MAX);
        rowLoClip_s = clipCell(rowLoRaw_s, ROW_MAX);
        rowHiClip_s = clipCell(rowHiRaw_s, ROW_MAX);
    end

    assign accept_s   = wrValid_r && wr_ready;
    assign lastCell_s = (col_r == colHi_r) && (row_r == rowHi_r);

    // State register.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_r <= IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Next-state logic; new frames are only honoured from IDLE.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            IDLE: begin
                if (startOfFrame && dig_enable) begin
                    nextState_s = LATCH;
                end else begin
                    nextState_s = IDLE;
                end
            end
            LATCH: begin
                if (outside_s) begin
                    nextState_s = IDLE;
                end else begin
                    nextState_s = SCAN;
                end
            end
            SCAN: begin
                if (accept_s && lastCell_s) begin
                    nextState_s = DONE;
                end else begin
                    nextState_s = SCAN;
                end
            end
            DONE:    nextState_s = IDLE;
            default: nextState_s = IDLE;
        endcase
    end

    // Output decode from the upcoming state so the outputs leave a register.
    always_comb begin
        wrValidNext_s = 1'b0;
        busyNext_s    = 1'b0;
        case (nextState_s)
            IDLE: begin
                wrValidNext_s = 1'b0;
                busyNext_s    = 1'b0;
            end
            LATCH: begin
                wrValidNext_s = 1'b0;
                busyNext_s    = 1'b1;
            end
            SCAN: begin
                wrValidNext_s = 1'b1;
                busyNext_s    = 1'b1;
            end
            DONE: begin
                wrValidNext_s = 1'b0;
                busyNext_s    = 1'b1;
            end
            default: begin
                wrValidNext_s = 1'b0;
                busyNext_s    = 1'b0;
            end
        endcase
    end

    // Registered outputs, captured position, scan ranges and cell cursor.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            wrValid_r <= 1'b0;
            busy_r    <= 1'b0;
            posX_r    <= 11'd0;
            posY_r    <= 11'd0;
            colLo_r   <= 6'd0;
            colHi_r   <= 6'd0;
            rowHi_r   <= 6'd0;
            col_r     <= 6'd0;
            row_r     <= 6'd0;
        end else begin
            wrValid_r <= wrValidNext_s;
            busy_r    <= busyNext_s;
            if ((state_r == IDLE) && (nextState_s == LATCH)) begin
                posX_r <= player_topLeftX;
                posY_r <= player_topLeftY;
            end
            if ((state_r == LATCH) && !outside_s) begin
                colLo_r <= colLoClip_s;
                colHi_r <= colHiClip_s;
                rowHi_r <= rowHiClip_s;
                col_r   <= colLoClip_s;
                row_r   <= rowLoClip_s;
            end else if ((state_r == SCAN) && accept_s && !lastCell_s) begin
                // Row-major walk: wrap column back to colLo at the row end.
                if (col_r == colHi_r) begin
                    col_r <= colLo_r;
                    row_r <= row_r + 6'd1;
                end else begin
                    col_r <= col_r + 6'd1;
                end
            end
        end
    end

`ifdef TERRAIN_DIG_STATS_EN
    logic [11:0] count_r;

    // Saturating count of accepted writes.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            count_r <= 12'd0;
        end else if (accept_s && (count_r != 12'd4095)) begin
            count_r <= count_r + 12'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign cells_dug_count = count_r;
`else
    assign cells_dug_count = 12'd0;
`endif

    assign wr_valid = wrValid_r;
    assign wr_col   = col_r;
    assign wr_row   = row_r;
    assign wr_data  = 1'b0;
    assign busy     = busy_r;

endmodule

// File: tb/tb_terrain_dig_writer.sv
// Scoreboard bench for terrain_dig_writer: directed footprints, stalls, reset mid-scan
// and counter behaviour (expectation follows TERRAIN_DIG_STATS_EN).
module tb_terrain_dig_writer;

    logic        clk;
    logic        resetN;
    logic        startOfFrame;
    logic        dig_enable;
    logic [10:0] player_topLeftX;
    logic [10:0] player_topLeftY;
    logic        wr_ready;
    logic        wr_valid;
    logic [5:0]  wr_col;
    logic [5:0]  wr_row;
    logic        wr_data;
    logic        busy;
    logic [11:0] cells_dug_count;

    terrain_dig_writer dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .dig_enable(dig_enable),
        .player_topLeftX(player_topLeftX), .player_topLeftY(player_topLeftY),
        .wr_ready(wr_ready), .wr_valid(wr_valid), .wr_col(wr_col), .wr_row(wr_row),
        .wr_data(wr_data), .busy(busy), .cells_dug_count(cells_dug_count)
    );

    typedef struct packed {
        logic [5:0] col;
        logic [5:0] row;
    } cell_t;

    cell_t expQ[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    acceptCount = 0;
    int    lastAcceptCyc = 0;
    int    expTotal = 0;
    bit    readyPattern = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // wr_ready driver: always 1, or the 1,0,0,1 stall pattern.
    initial begin
        wr_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (readyPattern) wr_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            else wr_ready = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pop and compare on every accepted write; verify stall holding.
    initial begin
        cell_t e;
        bit holdActive;
        logic [5:0] holdCol, holdRow;
        holdActive = 1'b0;
        holdCol = 6'd0;
        holdRow = 6'd0;
        forever begin
            @(negedge clk);
            if (!resetN) begin
                holdActive = 1'b0;
            end else begin
                if (holdActive) begin
                    chk("stall_hold_valid", wr_valid, 1);
                    chk("stall_hold_col", wr_col, holdCol);
                    chk("stall_hold_row", wr_row, holdRow);
                end
                if (wr_valid && wr_ready) begin
                    acceptCount++;
                    lastAcceptCyc = cyc;
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: got col=%0d row=%0d, expected no write", wr_col, wr_row);
                    end else begin
                        e = expQ.pop_front();
                        chk("wr_col", wr_col, e.col);
                        chk("wr_row", wr_row, e.row);
                        chk("wr_data", wr_data, 0);
                    end
                    holdActive = 1'b0;
                end else if (wr_valid) begin
                    holdActive = 1'b1;
                    holdCol = wr_col;
                    holdRow = wr_row;
                end else begin
                    holdActive = 1'b0;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expectCount;
`ifdef TERRAIN_DIG_STATS_EN
        chk("cells_dug_count", cells_dug_count, (expTotal > 4095) ? 4095 : expTotal);
`else
        chk("cells_dug_count", cells_dug_count, 0);
`endif
    endtask

    // One frame's dig at (x,y); expected cells given as hand-computed ranges.
    task automatic runScan(input int x, input int y, input int cLo, input int cHi,
                           input int rLo, input int rHi, input bit inject);
        int  n;
        bit  done;
        cell_t c;
        n = 0;
        for (int r = rLo; r <= rHi; r++) begin
            for (int k = cLo; k <= cHi; k++) begin
                c.col = 6'(k);
                c.row = 6'(r);
                expQ.push_back(c);
                n++;
            end
        end
        startOfFrame = 1'b1;
        dig_enable = 1'b1;
        player_topLeftX = 11'(x);
        player_topLeftY = 11'(y);
        tick;
        startOfFrame = 1'b0;
        dig_enable = 1'b0;
        player_topLeftX = 11'd700;
        chk("latch_wr_valid", wr_valid, 0);
        chk("latch_busy", busy, 1);
        tick;
        chk("first_wr_valid", wr_valid, (n > 0) ? 1 : 0);
        done = (n == 0);
        if (n == 0) chk("outside_busy_one_cycle", busy, 0);
        for (int t = 0; t < 400 && !done; t++) begin
            if (inject && t == 3) begin
                startOfFrame = 1'b1;
                dig_enable = 1'b1;
                player_topLeftX = 11'd300;
            end else begin
                startOfFrame = 1'b0;
                dig_enable = 1'b0;
            end
            tick;
            if (!busy) done = 1'b1;
        end
        startOfFrame = 1'b0;
        dig_enable = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL scan_timeout: busy still 1 after 400 cycles, expected 0");
        end else if (n > 0) begin
            chk("busy_fall_latency", cyc - lastAcceptCyc, 2);
        end
        if (inject) begin
            tick;
            chk("no_extra_scan", busy, 0);
        end
        chk("pending_writes", expQ.size(), 0);
        expQ.delete();
        expTotal += n;
        expectCount();
    endtask

    initial begin
        int base;
        bit reached;
        resetN = 1'b0;
        startOfFrame = 1'b0;
        dig_enable = 1'b0;
        player_topLeftX = 11'd0;
        player_topLeftY = 11'd0;
        tick;
        tick;
        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wr_col", wr_col, 0);
        chk("rst_wr_row", wr_row, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_count", cells_dug_count, 0);
        resetN = 1'b1;
        tick;

        runScan(32, 160, 0, 3, 0, 3, 1'b0);
        runScan(36, 160, 0, 4, 0, 3, 1'b1);
        runScan(0, 160, 1, 0, 0, 0, 1'b0);
        runScan(500, 160, 58, 59, 0, 3, 1'b0);
        readyPattern = 1'b1;
        runScan(32, 160, 0, 3, 0, 3, 1'b0);
        readyPattern = 1'b0;
        tick;

        // Reset right after the 5th accepted write of a scan.
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) expQ.push_back(cell_t'{col: 6'(k), row: 6'(r)});
        end
        base = acceptCount;
        startOfFrame = 1'b1;
        dig_enable = 1'b1;
        player_topLeftX = 11'd32;
        player_topLeftY = 11'd160;
        tick;
        startOfFrame = 1'b0;
        dig_enable = 1'b0;
        reached = 1'b0;
        for (int t = 0; t < 100 && !reached; t++) begin
            tick;
            if (acceptCount - base >= 5) reached = 1'b1;
        end
        if (!reached) begin
            checks++;
            errors++;
            $display("FAIL reset_wait_timeout: got %0d accepts, expected 5", acceptCount - base);
        end
        resetN = 1'b0;
        tick;
        chk("midscan_rst_wr_valid", wr_valid, 0);
        chk("midscan_rst_busy", busy, 0);
        chk("midscan_rst_count", cells_dug_count, 0);
        chk("midscan_rst_wr_col", wr_col, 0);
        chk("midscan_rst_wr_row", wr_row, 0);
        expQ.delete();
        expTotal = 0;
        resetN = 1'b1;
        tick;
        tick;
        chk("no_resume_busy", busy, 0);
        chk("no_resume_wr_valid", wr_valid, 0);

        // 300 frames push the counter past 4095 when statistics are enabled.
        for (int f = 0; f < 300; f++) runScan(32, 160, 0, 3, 0, 3, 1'b0);
        expectCount();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
